stream_argmax_unit: RTL and testbench

- Sequential successor to the two-input max comparator: finds the maximum value and its index over a streamed vector of arbitrary length.
- Sits after the ELM output layer. Consumes one output-neuron score per beat and returns the winning class index plus its score.
- Generalised in width and signedness. Adds a handshake, framing, tie policy, a count/overflow report, and an optional runner-up tracker.

---
 rtl/stream_argmax_unit_if.sv | 50 +++++
 rtl/stream_argmax_unit.sv | 146 ++++++++++++++
 tb/tb_stream_argmax_unit.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/stream_argmax_unit_if.sv
// stream_argmax_unit_if
//   Bundles the score stream and the result handshake of stream_argmax_unit.
//   Optional macro ARGMAX_RUNNER_UP_EN adds res_second / res_second_vld.
//
//   Score stream : in_valid, in_ready, in_data[DATA_W], in_last
//   Result       : res_valid, res_ready, res_max[DATA_W], res_idx[IDX_W],
//                  res_count[IDX_W+1], res_ovf
//                  (+ res_second[DATA_W], res_second_vld when enabled)
//
//   modport slave  : the argmax unit (consumes scores, produces the result)
//   modport master : the upstream producer / result consumer
interface stream_argmax_unit_if #(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              res_valid;
  logic              res_ready;
  logic [DATA_W-1:0] res_max;
  logic [IDX_W-1:0]  res_idx;
  logic [IDX_W:0]    res_count;
  logic              res_ovf;
`ifdef ARGMAX_RUNNER_UP_EN
  logic [DATA_W-1:0] res_second;
  logic              res_second_vld;

  modport slave (
    input  in_valid, in_data, in_last, res_ready,
    output in_ready, res_valid, res_max, res_idx, res_count, res_ovf,
           res_second, res_second_vld
  );
  modport master (
    output in_valid, in_data, in_last, res_ready,
    input  in_ready, res_valid, res_max, res_idx, res_count, res_ovf,
           res_second, res_second_vld
  );
`else
  modport slave (
    input  in_valid, in_data, in_last, res_ready,
    output in_ready, res_valid, res_max, res_idx, res_count, res_ovf
  );
  modport master (
    output in_valid, in_data, in_last, res_ready,
    input  in_ready, res_valid, res_max, res_idx, res_count, res_ovf
  );
`endif
endinterface

// File: rtl/stream_argmax_unit.sv
// stream_argmax_unit
//   Streaming argmax over a framed vector of scores (e.g. ELM output layer).
//   One score per accepted beat; when the in_last beat is accepted the unit
//   holds the winning score, its zero-based index, the element count and an
//   overflow flag until the result is taken. Ties keep the earliest index.
//   Optional macro ARGMAX_RUNNER_UP_EN adds second-largest score tracking.
//
//   Ports:
//     clk  : rising-edge clock
//     rst  : synchronous, active-high reset
//     bus  : stream_argmax_unit_if.slave (score stream + result handshake)
//
//   Parameters:
//     DATA_W : score width
//     IDX_W  : index width; frames hold up to 2^IDX_W indexed elements
//     SIGNED : 0 = unsigned compare, 1 = two's-complement compare
module stream_argmax_unit #(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 8,
  parameter int SIGNED = 0
) (
  input logic                   clk,
  input logic                   rst,
  stream_argmax_unit_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  localparam logic [IDX_W:0] CNT_MAX = {1'b1, {IDX_W{1'b0}}};
  localparam logic [IDX_W:0] CNT_TWO = (IDX_W+1)'(2);

  state_t            state_q;
  logic [DATA_W-1:0] best_val_q, best_val_d;
  logic [IDX_W-1:0]  best_idx_q, best_idx_d;
  logic [IDX_W:0]    count_q,    count_d;
  logic              ovf_q,      ovf_d;
`ifdef ARGMAX_RUNNER_UP_EN
  logic [DATA_W-1:0] second_q,   second_d;
`endif

  logic accept;
  logic at_cap;
  logic displace;

  // Strict greater-than in the configured number system.
  function automatic logic score_gt(input logic [DATA_W-1:0] a,
                                    input logic [DATA_W-1:0] b);
    logic signed [DATA_W-1:0] a_s;
    logic signed [DATA_W-1:0] b_s;
    a_s = a;
    b_s = b;
    if (SIGNED != 0) return a_s > b_s;
    else             return a > b;
  endfunction

  // Element counter saturates at 2^IDX_W.
  function automatic logic [IDX_W:0] count_sat_inc(input logic [IDX_W:0] c);
    if (c == CNT_MAX) return c;
    else              return c + (IDX_W+1)'(1);
  endfunction

  assign accept   = bus.in_valid && bus.in_ready;
  assign at_cap   = (count_q == CNT_MAX);
  assign displace = score_gt(bus.in_data, best_val_q);

  // Candidate update for a beat accepted in ACCUM.
  always_comb begin
    best_val_d = best_val_q;
    best_idx_d = best_idx_q;
    count_d    = count_sat_inc(count_q);
    ovf_d      = ovf_q | at_cap;
    if (displace) begin
      best_val_d = bus.in_data;
      // Beyond 2^IDX_W elements the index is not representable: keep the
      // last indexable winner, but still let the value win.
      if (!at_cap) best_idx_d = count_q[IDX_W-1:0];
    end
`ifdef ARGMAX_RUNNER_UP_EN
    second_d = second_q;
    if (displace)
      second_d = best_val_q;
    else if ((count_q < CNT_TWO) || score_gt(bus.in_data, second_q))
      second_d = bus.in_data;   // also catches ties with best
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      best_val_q <= '0;
      best_idx_q <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
`ifdef ARGMAX_RUNNER_UP_EN
      second_q   <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            best_val_q <= bus.in_data;
            best_idx_q <= '0;
            count_q    <= (IDX_W+1)'(1);
            ovf_q      <= 1'b0;
`ifdef ARGMAX_RUNNER_UP_EN
            second_q   <= '0;
`endif
            state_q    <= bus.in_last ? HOLD : ACCUM;
          end
        end
        ACCUM: begin
          if (accept) begin
            best_val_q <= best_val_d;
            best_idx_q <= best_idx_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
`ifdef ARGMAX_RUNNER_UP_EN
            second_q   <= second_d;
`endif
            if (bus.in_last) state_q <= HOLD;
          end
        end
        HOLD: begin
          // No same-cycle restart: the next frame starts from IDLE.
          if (bus.res_ready) begin
            state_q <= IDLE;
            ovf_q   <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = !rst && (state_q != HOLD);
  assign bus.res_valid = (state_q == HOLD);
  assign bus.res_max   = best_val_q;
  assign bus.res_idx   = best_idx_q;
  assign bus.res_count = count_q;
  assign bus.res_ovf   = ovf_q;
`ifdef ARGMAX_RUNNER_UP_EN
  assign bus.res_second     = second_q;
  assign bus.res_second_vld = (count_q >= CNT_TWO);
`endif

endmodule

// File: tb/tb_stream_argmax_unit.sv
module tb_stream_argmax_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  stream_argmax_unit_if #(.DATA_W(32), .IDX_W(8)) if0 ();
  stream_argmax_unit_if #(.DATA_W(32), .IDX_W(8)) if1 ();
  stream_argmax_unit_if #(.DATA_W(32), .IDX_W(2)) if2 ();

  stream_argmax_unit #(.DATA_W(32), .IDX_W(8), .SIGNED(0)) u_uns (.clk(clk), .rst(rst), .bus(if0));
  stream_argmax_unit #(.DATA_W(32), .IDX_W(8), .SIGNED(1)) u_sgn (.clk(clk), .rst(rst), .bus(if1));
  stream_argmax_unit #(.DATA_W(32), .IDX_W(2), .SIGNED(0)) u_sml (.clk(clk), .rst(rst), .bus(if2));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int s, input logic v, input logic [31:0] d, input logic l);
    case (s)
      0: begin if0.in_valid = v; if0.in_data = d; if0.in_last = l; end
      1: begin if1.in_valid = v; if1.in_data = d; if1.in_last = l; end
      default: begin if2.in_valid = v; if2.in_data = d; if2.in_last = l; end
    endcase
  endtask

  task automatic set_rr(input int s, input logic r);
    case (s)
      0: if0.res_ready = r;
      1: if1.res_ready = r;
      default: if2.res_ready = r;
    endcase
  endtask

  task automatic peek(input int s, output logic rv, output logic [31:0] mx,
                      output logic [7:0] idx, output logic [8:0] cnt,
                      output logic ovf, output logic ir);
    case (s)
      0: begin rv = if0.res_valid; mx = if0.res_max; idx = if0.res_idx;
               cnt = if0.res_count; ovf = if0.res_ovf; ir = if0.in_ready; end
      1: begin rv = if1.res_valid; mx = if1.res_max; idx = if1.res_idx;
               cnt = if1.res_count; ovf = if1.res_ovf; ir = if1.in_ready; end
      default: begin rv = if2.res_valid; mx = if2.res_max; idx = 8'(if2.res_idx);
               cnt = 9'(if2.res_count); ovf = if2.res_ovf; ir = if2.in_ready; end
    endcase
  endtask

  // One accepted beat; leaves in_valid low afterwards.
  task automatic beat(input int s, input logic [31:0] d, input logic l);
    drive(s, 1'b1, d, l);
    step();
    drive(s, 1'b0, 32'h0, 1'b0);
  endtask

  // Check the full result record of one unit.
  task automatic chk_res(input string tag, input int s, input logic [31:0] emax,
                         input logic [7:0] eidx, input logic [8:0] ecnt, input logic eovf);
    logic rv, ovf, ir;
    logic [31:0] mx;
    logic [7:0] idx;
    logic [8:0] cnt;
    peek(s, rv, mx, idx, cnt, ovf, ir);
    chk({tag, ".valid"}, 64'(rv), 64'(1));
    chk({tag, ".max"},   64'(mx), 64'(emax));
    chk({tag, ".idx"},   64'(idx), 64'(eidx));
    chk({tag, ".count"}, 64'(cnt), 64'(ecnt));
    chk({tag, ".ovf"},   64'(ovf), 64'(eovf));
    chk({tag, ".in_ready"}, 64'(ir), 64'(0));
  endtask

  // Take the result and verify the unit returns to IDLE.
  task automatic release_res(input string tag, input int s);
    logic rv, ovf, ir;
    logic [31:0] mx;
    logic [7:0] idx;
    logic [8:0] cnt;
    set_rr(s, 1'b1);
    step();
    set_rr(s, 1'b0);
    peek(s, rv, mx, idx, cnt, ovf, ir);
    chk({tag, ".rel_valid"}, 64'(rv), 64'(0));
    chk({tag, ".rel_in_ready"}, 64'(ir), 64'(1));
  endtask

  initial begin : main
    logic rv, ovf, ir;
    logic [31:0] mx;
    logic [7:0] idx;
    logic [8:0] cnt;

    for (int s = 0; s < 3; s++) begin
      drive(s, 1'b0, 32'h0, 1'b0);
      set_rr(s, 1'b0);
    end
    rst = 1'b1;
    step();
    step();

    // Reset state, all three units
    for (int s = 0; s < 3; s++) begin
      peek(s, rv, mx, idx, cnt, ovf, ir);
      chk($sformatf("rst%0d.valid", s), 64'(rv), 64'(0));
      chk($sformatf("rst%0d.in_ready", s), 64'(ir), 64'(0));
      chk($sformatf("rst%0d.max", s), 64'(mx), 64'(0));
      chk($sformatf("rst%0d.count", s), 64'(cnt), 64'(0));
      chk($sformatf("rst%0d.ovf", s), 64'(ovf), 64'(0));
    end
    rst = 1'b0;
    #1;
    peek(0, rv, mx, idx, cnt, ovf, ir);
    chk("postrst.in_ready", 64'(ir), 64'(1));

    // Unsigned 3,9,2,9 with an idle gap; tie keeps idx 1
    beat(0, 32'd3, 1'b0);
    beat(0, 32'd9, 1'b0);
    step();
    step();
    beat(0, 32'd2, 1'b0);
    peek(0, rv, mx, idx, cnt, ovf, ir);
    chk("t1.not_yet_valid", 64'(rv), 64'(0));
    beat(0, 32'd9, 1'b1);
    chk_res("t1", 0, 32'd9, 8'd1, 9'd4, 1'b0);
    release_res("t1", 0);

    // Signed vs unsigned interpretation of the same frame
    beat(1, 32'hFFFF_FFFE, 1'b0);
    beat(1, 32'h0000_0001, 1'b0);
    beat(1, 32'h8000_0000, 1'b1);
    chk_res("t2s", 1, 32'h0000_0001, 8'd1, 9'd3, 1'b0);
    release_res("t2s", 1);
    beat(0, 32'hFFFF_FFFE, 1'b0);
    beat(0, 32'h0000_0001, 1'b0);
    beat(0, 32'h8000_0000, 1'b1);
    chk_res("t2u", 0, 32'hFFFF_FFFE, 8'd0, 9'd3, 1'b0);
    release_res("t2u", 0);

    // Single element, back-pressured result; offered beats must be ignored
    beat(0, 32'h55, 1'b1);
    drive(0, 1'b1, 32'hAA, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk_res($sformatf("t3.hold%0d", i), 0, 32'h55, 8'd0, 9'd1, 1'b0);
    end
    drive(0, 1'b0, 32'h0, 1'b0);
    release_res("t3", 0);
    beat(0, 32'h12, 1'b1);
    chk_res("t3.next", 0, 32'h12, 8'd0, 9'd1, 1'b0);
    release_res("t3.next", 0);

    // Overflow with IDX_W=2
    beat(2, 32'd1, 1'b0);
    beat(2, 32'd2, 1'b0);
    beat(2, 32'd3, 1'b0);
    beat(2, 32'd4, 1'b0);
    beat(2, 32'd9, 1'b0);
    beat(2, 32'd0, 1'b1);
    chk_res("t4", 2, 32'd9, 8'd3, 9'd4, 1'b1);
    release_res("t4", 2);
    peek(2, rv, mx, idx, cnt, ovf, ir);
    chk("t4.ovf_cleared_idle", 64'(ovf), 64'(0));
    beat(2, 32'd5, 1'b0);
    beat(2, 32'd6, 1'b1);
    chk_res("t4.next", 2, 32'd6, 8'd1, 9'd2, 1'b0);
    release_res("t4.next", 2);

    // Reset mid-frame discards partial state
    beat(0, 32'd5, 1'b0);
    beat(0, 32'd8, 1'b0);
    rst = 1'b1;
    step();
    peek(0, rv, mx, idx, cnt, ovf, ir);
    chk("t5.rst_valid", 64'(rv), 64'(0));
    chk("t5.rst_in_ready", 64'(ir), 64'(0));
    chk("t5.rst_max", 64'(mx), 64'(0));
    rst = 1'b0;
    step();
    beat(0, 32'd1, 1'b1);
    chk_res("t5", 0, 32'd1, 8'd0, 9'd1, 1'b0);
    release_res("t5", 0);

`ifdef ARGMAX_RUNNER_UP_EN
    // Runner-up tracking
    beat(0, 32'd4, 1'b0);
    beat(0, 32'd10, 1'b0);
    beat(0, 32'd6, 1'b0);
    beat(0, 32'd10, 1'b1);
    chk_res("t6", 0, 32'd10, 8'd1, 9'd4, 1'b0);
    chk("t6.second", 64'(if0.res_second), 64'(10));
    chk("t6.second_vld", 64'(if0.res_second_vld), 64'(1));
    release_res("t6", 0);
    beat(0, 32'd7, 1'b0);
    beat(0, 32'd7, 1'b1);
    chk_res("t6.tie", 0, 32'd7, 8'd0, 9'd2, 1'b0);
    chk("t6.tie_second", 64'(if0.res_second), 64'(7));
    release_res("t6.tie", 0);
    beat(0, 32'd3, 1'b1);
    chk("t6.single_second_vld", 64'(if0.res_second_vld), 64'(0));
    release_res("t6.single", 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Watchdog: the directed sequence is far shorter than this.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

endmodule
